// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_pkg
// Purpose  : Shared types and constants for the serial word streamer and the
//            101 detector environment that consumes its stream.
// Revision : 1.0 - initial release
// ============================================================================
package serial_pkg;

  // Streamer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Level held on the serial line whenever no word bit is being driven
  localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

endpackage
`default_nettype wire

// File: rtl/serial_word_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_streamer_if
// Purpose  : Word-side valid/ready handshake plus the serial stream outputs.
//            master = word source / stream sink, slave = streamer.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_word_streamer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             word_done;

  modport master (
    output data_in, data_valid,
    input  data_ready, serial_out, serial_valid, word_done
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, serial_out, serial_valid, word_done
  );
endinterface
`default_nettype wire

// File: rtl/word_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : word_hold_buf
// Purpose  : One-entry valid/ready hold register between the word source and
//            the shift stage. Captures on accept, empties on release.
// Revision : 1.0 - initial release
// ============================================================================
module word_hold_buf
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             release_word,
  output logic             hold_full,
  output logic [WIDTH-1:0] hold_data
);

  logic accept;

  // Ready is forced low during reset so nothing is captured on a reset edge
  assign data_ready = !hold_full && !rst;
  assign accept     = data_valid && data_ready;

  // Capture a word on accept; the shift stage empties the slot on release.
  // Accept and release never coincide because ready is low while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= data_in;
    end else if (release_word) begin
      hold_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_word_streamer.sv
`default_nettype none
// ============================================================================
// Module   : serial_word_streamer
// Purpose  : Parallel-to-serial front end. Words enter a one-entry hold
//            buffer, then shift out one bit per clock with per-bit valid,
//            end-of-word pulse and an optional idle gap between words.
// Revision : 1.0 - initial release
// ============================================================================
module serial_word_streamer
  import serial_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_word_streamer_if.slave  bus,
  output logic                   busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0]        GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [7:0]         gap_cnt, gap_cnt_nxt;
  logic [WIDTH-1:0]   shreg, shreg_nxt;
  logic               out_bit, out_bit_nxt;
  logic               out_valid, out_valid_nxt;
  logic               out_done, out_done_nxt;
  logic               transfer;
  logic               hold_full;
  logic [WIDTH-1:0]   hold_data;

  // Bit presented first from a word under the configured ordering
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the head position
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  word_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk          (clk),
    .rst          (rst),
    .data_in      (bus.data_in),
    .data_valid   (bus.data_valid),
    .data_ready   (bus.data_ready),
    .release_word (transfer),
    .hold_full    (hold_full),
    .hold_data    (hold_data)
  );

  // Next-state, counters and next registered outputs; a transfer from the
  // hold buffer overrides whatever the current state decided
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    shreg_nxt     = shreg;
    transfer      = 1'b0;
    out_bit_nxt   = IDLE_LEVEL;
    out_valid_nxt = 1'b0;
    out_done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (hold_full) transfer = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          if (GAP_CYCLES > 0) begin
            state_nxt   = ST_GAP;
            gap_cnt_nxt = 8'd0;
          end else if (hold_full) begin
            transfer = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          bit_cnt_nxt   = bit_cnt + 1'b1;
          shreg_nxt     = advance(shreg);
          out_bit_nxt   = head_bit(shreg_nxt);
          out_valid_nxt = 1'b1;
          out_done_nxt  = (bit_cnt_nxt == BIT_LAST);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (hold_full) transfer = 1'b1;
          else           state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (transfer) begin
      state_nxt     = ST_SHIFT;
      bit_cnt_nxt   = '0;
      shreg_nxt     = hold_data;
      out_bit_nxt   = head_bit(hold_data);
      out_valid_nxt = 1'b1;
      out_done_nxt  = 1'b0;
    end
  end

  // State, counter, shift register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= 8'd0;
      shreg     <= '0;
      out_bit   <= IDLE_LEVEL;
      out_valid <= 1'b0;
      out_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      shreg     <= shreg_nxt;
      out_bit   <= out_bit_nxt;
      out_valid <= out_valid_nxt;
      out_done  <= out_done_nxt;
    end
  end

  assign bus.serial_out   = out_bit;
  assign bus.serial_valid = out_valid;
  assign bus.word_done    = out_done;
  assign busy             = (state != ST_IDLE) || hold_full;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_word_streamer
// Purpose  : Self-checking bench. Two streamers: A (MSB first, no gap, idle 0)
//            and B (LSB first, 2-cycle gap, idle 1). A frame-position model
//            predicts every output each cycle; a word scoreboard checks order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_word_streamer;
  import serial_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_v = 2'b11;
  logic [1:0] src_v = 2'b00;
  logic [7:0] src_d [2];
  logic [1:0] rdy, sv, so, wd, bz;
  logic       busy_a, busy_b;

  serial_word_streamer_if #(.WIDTH(8)) bus_a ();
  serial_word_streamer_if #(.WIDTH(8)) bus_b ();

  serial_word_streamer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0))
    dut_a (.clk(clk), .rst(rst_v[0]), .bus(bus_a), .busy(busy_a));
  serial_word_streamer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1))
    dut_b (.clk(clk), .rst(rst_v[1]), .bus(bus_b), .busy(busy_b));

  assign bus_a.data_in = src_d[0];  assign bus_a.data_valid = src_v[0];
  assign bus_b.data_in = src_d[1];  assign bus_b.data_valid = src_v[1];
  assign rdy = {bus_b.data_ready,   bus_a.data_ready};
  assign sv  = {bus_b.serial_valid, bus_a.serial_valid};
  assign so  = {bus_b.serial_out,   bus_a.serial_out};
  assign wd  = {bus_b.word_done,    bus_a.word_done};
  assign bz  = {busy_b, busy_a};

  int vectors = 0;
  int miscompares = 0;

  // Per-instance configuration as the model sees it
  function automatic int  gap_of (input int d); return (d == 0) ? 0 : 2; endfunction
  function automatic bit  msb_of (input int d); return (d == 0); endfunction
  function automatic logic idle_of(input int d); return (d == 0) ? 1'b0 : 1'b1; endfunction

  // Model: a word occupies a frame of 8 + gap cycles; position 0..7 are bits
  bit         m_act [2];
  int         m_pos [2];
  logic [7:0] m_word[2];
  bit         m_full[2];
  logic [7:0] m_hold[2];
  bit         m_rst [2];
  logic [7:0] exp_q [2][$];
  logic [7:0] col   [2];

  int cyc = 0;
  int valid_cnt[2], done_cnt[2], done_gap[2], last_done[2], run[2], last_run[2];

  task automatic model_step(input int d, input bit r, input bit v, input logic [7:0] din);
    bit acc, free;
    m_rst[d] = r;
    if (r) begin
      m_act[d] = 0; m_full[d] = 0; exp_q[d].delete(); col[d] = 8'h00;
      return;
    end
    acc  = v && !m_full[d];
    free = !m_act[d] || (m_pos[d] == 8 + gap_of(d) - 1);
    if (free) begin
      if (m_full[d]) begin
        m_act[d] = 1; m_pos[d] = 0; m_word[d] = m_hold[d]; m_full[d] = 0;
      end else begin
        m_act[d] = 0;
      end
    end else begin
      m_pos[d]++;
    end
    if (acc) begin
      m_full[d] = 1; m_hold[d] = din; exp_q[d].push_back(din);
    end
  endtask

  // Expected {ready, busy, valid, out, done}
  function automatic logic [4:0] exp_vec(input int d);
    bit   val = m_act[d] && (m_pos[d] < 8);
    logic ob  = val ? m_word[d][msb_of(d) ? 7 - m_pos[d] : m_pos[d]] : idle_of(d);
    return {!m_full[d] && !m_rst[d], m_act[d] || m_full[d], val, ob, m_act[d] && (m_pos[d] == 7)};
  endfunction

  // Every cycle: advance model, compare all outputs, assemble and order-check words
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d, rst_v[d], src_v[d], src_d[d]);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic [4:0] act;
      logic [4:0] ex;
      act = {rdy[d], bz[d], sv[d], so[d], wd[d]};
      ex  = exp_vec(d);
      vectors++;
      if (act !== ex) begin
        miscompares++;
        $display("FAIL cycle_%0d dut%0d {ready,busy,valid,out,done} got %b want %b", cyc, d, act, ex);
      end
      if (sv[d] === 1'b1) begin
        valid_cnt[d]++;
        run[d]++;
        col[d] = msb_of(d) ? {col[d][6:0], so[d]} : {so[d], col[d][7:1]};
      end else begin
        if (run[d] != 0) last_run[d] = run[d];
        run[d] = 0;
      end
      if (wd[d] === 1'b1) begin
        done_cnt[d]++;
        done_gap[d]  = cyc - last_done[d];
        last_done[d] = cyc;
        vectors++;
        if (exp_q[d].size() == 0) begin
          miscompares++;
          $display("FAIL word_order dut%0d got %h want none", d, col[d]);
        end else begin
          logic [7:0] w;
          w = exp_q[d].pop_front();
          if (col[d] !== w) begin
            miscompares++;
            $display("FAIL word_order dut%0d got %h want %h", d, col[d], w);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Present a word at a negedge and hold it until accepted; returns at the
  // negedge following the accepting edge with valid still asserted
  task automatic send(input int d, input logic [7:0] w);
    src_d[d] = w;
    src_v[d] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (rdy[d]) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    vectors++;
    miscompares++;
    $display("FAIL send_timeout dut%0d got no ready want ready for %h", d, w);
  endtask

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp;   // {ready, busy, valid, out, done}
  } vec_t;

  vec_t tv [14];
  bit   pend [2];

  initial begin
    int bd, bv, va;
    src_d[0] = 8'h00; src_d[1] = 8'h00;

    // Reset, then a single 8'hA5 on A: bits 1,0,1,0,0,1,0,1 from the 2nd edge
    tv[0]  = '{1'b1, 1'b0, 8'h00, 5'b00000};
    tv[1]  = '{1'b1, 1'b0, 8'h00, 5'b00000};
    tv[2]  = '{1'b0, 1'b0, 8'h00, 5'b10000};
    tv[3]  = '{1'b0, 1'b1, 8'hA5, 5'b01000};
    tv[4]  = '{1'b0, 1'b0, 8'h00, 5'b11110};
    tv[5]  = '{1'b0, 1'b0, 8'h00, 5'b11100};
    tv[6]  = '{1'b0, 1'b0, 8'h00, 5'b11110};
    tv[7]  = '{1'b0, 1'b0, 8'h00, 5'b11100};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 5'b11100};
    tv[9]  = '{1'b0, 1'b0, 8'h00, 5'b11110};
    tv[10] = '{1'b0, 1'b0, 8'h00, 5'b11100};
    tv[11] = '{1'b0, 1'b0, 8'h00, 5'b11111};
    tv[12] = '{1'b0, 1'b0, 8'h00, 5'b10000};
    tv[13] = '{1'b0, 1'b0, 8'h00, 5'b10000};

    for (int i = 0; i < 14; i++) begin
      logic [4:0] act;
      @(negedge clk);
      rst_v[0] = tv[i].rst;
      src_v[0] = tv[i].valid;
      src_d[0] = tv[i].data;
      @(posedge clk);
      #1;
      act = {rdy[0], bz[0], sv[0], so[0], wd[0]};
      vectors++;
      if (act !== tv[i].exp) begin
        miscompares++;
        $display("FAIL table_%0d {ready,busy,valid,out,done} got %b want %b", i, act, tv[i].exp);
      end
    end
    @(negedge clk);
    rst_v[1] = 1'b0;
    @(negedge clk);

    // Back-to-back on A: 16 contiguous valid cycles, done pulses 8 apart
    bd = done_cnt[0];
    send(0, 8'hA5); send(0, 8'h3C); src_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("b2b_run_len", last_run[0], 16);
    check("b2b_done_spacing", done_gap[0], 8);
    check("b2b_done_count", done_cnt[0] - bd, 2);

    // B: 8'h05 LSB first then a held second word; 2 idle cycles between
    bd = done_cnt[1];
    send(1, 8'h05); send(1, 8'hC3); src_v[1] = 1'b0;
    repeat (25) @(negedge clk);
    check("gap_done_spacing", done_gap[1], 10);
    check("gap_done_count", done_cnt[1] - bd, 2);
    check("gap_run_len", last_run[1], 8);

    // Backpressure on A: three words with valid held, none lost
    bd = done_cnt[0];
    send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); src_v[0] = 1'b0;
    repeat (35) @(negedge clk);
    check("bp_done_count", done_cnt[0] - bd, 3);
    check("bp_queue_empty", exp_q[0].size(), 0);

    // Reset on A while bit 3 of 8'hFF is out and 8'h81 waits in the buffer
    bd = done_cnt[0];
    bv = valid_cnt[0];
    send(0, 8'hFF); send(0, 8'h81); src_v[0] = 1'b0;
    begin : find_bit3
      for (int k = 0; k < 30; k++) begin
        if (valid_cnt[0] - bv == 4) disable find_bit3;
        @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL rst_mid_timeout got %0d bits want 4", valid_cnt[0] - bv);
    end
    rst_v[0] = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", int'(sv[0]), 0);
    check("rst_mid_busy", int'(bz[0]), 0);
    check("rst_mid_ready", int'(rdy[0]), 0);
    rst_v[0] = 1'b0;
    va = valid_cnt[0];
    repeat (20) @(negedge clk);
    check("rst_mid_no_residual", valid_cnt[0] - va, 0);
    check("rst_mid_no_done", done_cnt[0] - bd, 0);

    // Random traffic on both instances with occasional resets
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst_v[d])                          rst_v[d] = 1'b0;
        else if ($urandom_range(0, 299) == 0)  rst_v[d] = 1'b1;
        if (pend[d]) begin
          if ($urandom_range(0, 1) == 1) begin
            src_d[d] = 8'($urandom); src_v[d] = 1'b1;
          end else begin
            src_v[d] = 1'b0;
          end
        end else if (!src_v[d] && $urandom_range(0, 2) == 0) begin
          src_d[d] = 8'($urandom); src_v[d] = 1'b1;
        end
      end
      #1;
      for (int d = 0; d < 2; d++) pend[d] = src_v[d] && rdy[d];
    end
    @(negedge clk);
    src_v = 2'b00;
    rst_v = 2'b00;
    repeat (40) @(negedge clk);
    check("drain_queue_a", exp_q[0].size(), 0);
    check("drain_queue_b", exp_q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
